// File: rtl/mul_share_ctrl.sv
// Shares one fixed-latency pipelined multiplier between PORTS_N requesters, returning tagged products.
// Define MUL_SHARE_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mul_share_ctrl #(
    parameter int PORTS_N = 4,
    parameter int PORT_W  = 2,
    parameter int DATA_W  = 18,
    parameter int MUL_LAT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PORTS_N-1:0]          req_in,
    input  logic [PORTS_N*DATA_W-1:0]   a_in,
    input  logic [PORTS_N*DATA_W-1:0]   b_in,
    output logic [PORTS_N-1:0]          ack_out,
    output logic [PORTS_N-1:0]          res_vld_out,
    output logic signed [2*DATA_W-1:0]  res_out,
    output logic                        mul_vld_out,
    output logic signed [DATA_W-1:0]    mul_a_out,
    output logic signed [DATA_W-1:0]    mul_b_out,
    input  logic signed [2*DATA_W-1:0]  mul_res_in
);

    logic [PORTS_N-1:0] pending;
    logic [PORTS_N-1:0] elig;
    logic [PORTS_N-1:0] set_mask;
    logic [PORTS_N-1:0] clr_mask;
    logic               found;
    logic [PORT_W-1:0]  win;
    logic [PORT_W-1:0]  iss_tag;
    logic               tag_vld_p [MUL_LAT];
    logic [PORT_W-1:0]  tag_id_p  [MUL_LAT];
`ifndef MUL_SHARE_FIXED_PRIO_EN
    logic [PORT_W-1:0]  rr_ptr;
    logic [PORT_W-1:0]  idx_c;
`endif

    function automatic logic [PORTS_N-1:0] to_onehot(input logic [PORT_W-1:0] id);
        to_onehot     = '0;
        to_onehot[id] = 1'b1;
    endfunction

    // A port stays masked while its product is in flight; pending clears on the return edge
    assign elig = req_in & ~pending;

    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef MUL_SHARE_FIXED_PRIO_EN
        for (int i = PORTS_N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                win   = PORT_W'(i);
            end
        end
`else
        idx_c = '0;
        for (int i = 0; i < PORTS_N; i++) begin
            idx_c = PORT_W'((int'(rr_ptr) + i) % PORTS_N);
            if (!found && elig[idx_c]) begin
                found = 1'b1;
                win   = idx_c;
            end
        end
`endif
    end

    assign set_mask = found ? to_onehot(win) : '0;
    assign clr_mask = tag_vld_p[MUL_LAT-1] ? to_onehot(tag_id_p[MUL_LAT-1]) : '0;

    // Issue stage: operands and tag launched toward the multiplier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_vld_out <= 1'b0;
            mul_a_out   <= '0;
            mul_b_out   <= '0;
            ack_out     <= '0;
            iss_tag     <= '0;
            pending     <= '0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            mul_vld_out <= found;
            ack_out     <= set_mask;
            pending     <= (pending & ~clr_mask) | set_mask;
            if (found) begin
                mul_a_out <= a_in[int'(win)*DATA_W +: DATA_W];
                mul_b_out <= b_in[int'(win)*DATA_W +: DATA_W];
                iss_tag   <= win;
`ifndef MUL_SHARE_FIXED_PRIO_EN
                rr_ptr    <= PORT_W'((int'(win) + 1) % PORTS_N);
`endif
            end
        end
    end

    // Tag pipe: mirrors multiplier latency so the tag meets its product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_vld_p[i] <= 1'b0;
                tag_id_p[i]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= mul_vld_out;
            tag_id_p[0]  <= iss_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
            end
        end
    end

    // Return stage: product captured and routed to the issuing port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_vld_out <= '0;
            res_out     <= '0;
        end else begin
            res_vld_out <= clr_mask;
            if (tag_vld_p[MUL_LAT-1]) begin
                res_out <= mul_res_in;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural fixed-latency multiplier.
module tb_mul_share_ctrl;

    localparam int PORTS_N = 4;
    localparam int PORT_W  = 2;
    localparam int DATA_W  = 18;
    localparam int MUL_LAT = 3;
    localparam int PW      = 2 * DATA_W;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [PORTS_N-1:0]          req_in = '0;
    logic [PORTS_N*DATA_W-1:0]   a_in = '0;
    logic [PORTS_N*DATA_W-1:0]   b_in = '0;
    logic [PORTS_N-1:0]          ack_out;
    logic [PORTS_N-1:0]          res_vld_out;
    logic [PW-1:0]               res_out;
    logic                        mul_vld_out;
    logic signed [DATA_W-1:0]    mul_a_out;
    logic signed [DATA_W-1:0]    mul_b_out;
    logic signed [PW-1:0]        mul_res_in;
    logic signed [PW-1:0]        mpipe [MUL_LAT];

    mul_share_ctrl #(
        .PORTS_N(PORTS_N), .PORT_W(PORT_W), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .a_in(a_in), .b_in(b_in),
        .ack_out(ack_out), .res_vld_out(res_vld_out), .res_out(res_out),
        .mul_vld_out(mul_vld_out), .mul_a_out(mul_a_out), .mul_b_out(mul_b_out),
        .mul_res_in(mul_res_in)
    );

    always #5 clk = ~clk;

    // Multiplier model: product of the operands on the bus MUL_LAT cycles later
    always @(posedge clk) begin
        mpipe[0] <= mul_a_out * mul_b_out;
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_res_in = mpipe[MUL_LAT-1];

    typedef struct {
        int            port;
        logic [PW-1:0] prod;
        int            due;
    } exp_t;

    exp_t               sb_q[$];
    int                 ack_log[$];
    int                 ack_cyc[$];
    logic [PORTS_N-1:0] outstanding = '0;
    logic [PORTS_N-1:0] hold = '0;
    int                 cyc = 0;
    int                 n_chk = 0;
    int                 n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return PW'(pa * pb);
    endfunction

    function automatic logic [PORTS_N-1:0] onehot(input int p);
        logic [PORTS_N-1:0] m;
        m    = '0;
        m[p] = 1'b1;
        return m;
    endfunction

    task automatic set_ops(input int p, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        a_in[p*DATA_W +: DATA_W] = a;
        b_in[p*DATA_W +: DATA_W] = b;
    endtask

    // One clock: sample outputs after the edge, score returns, record issues, update requesters
    task automatic step();
        exp_t e;
        int   p;
        @(posedge clk);
        #1;
        cyc++;
        if (res_vld_out != '0) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_res", res_vld_out, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("res_port", res_vld_out, onehot(e.port));
                check_eq("res_val", res_out, e.prod);
                check_eq("res_lat", cyc, e.due);
                outstanding[e.port] = 1'b0;
            end
        end
        if (ack_out != '0) begin
            check_eq("ack_onehot", $countones(ack_out), 1);
            p = 0;
            for (int k = 0; k < PORTS_N; k++) if (ack_out[k]) p = k;
            check_eq("dbl_issue", outstanding[p], 0);
            outstanding[p] = 1'b1;
            e.port = p;
            e.prod = ref_mul(a_in[p*DATA_W +: DATA_W], b_in[p*DATA_W +: DATA_W]);
            e.due  = cyc + MUL_LAT + 1;
            sb_q.push_back(e);
            ack_log.push_back(p);
            ack_cyc.push_back(cyc);
            if (hold[p]) set_ops(p, DATA_W'($urandom), DATA_W'($urandom));
            else req_in[p] = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (sb_q.size() > 0 || req_in != '0); i++) step();
        check_eq({tag, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        req_in = '0;
        hold   = '0;
        #1;
        check_eq("rst_ack", ack_out, 0);
        check_eq("rst_res_vld", res_vld_out, 0);
        check_eq("rst_mul_vld", mul_vld_out, 0);
        check_eq("rst_res", res_out, 0);
        check_eq("rst_mul_ab", {mul_a_out, mul_b_out}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        ack_log.delete();
        ack_cyc.delete();
        outstanding = '0;
    endtask

    initial begin
        #3;
        do_reset();

        // Single request, product latency four cycles after ack
        set_ops(1, DATA_W'(3), DATA_W'(-5));
        req_in[1] = 1'b1;
        step();
        check_eq("t1_ack", ack_out, 4'b0010);
        drain("t1");
        check_eq("t1_res", res_out, 36'hF_FFFF_FFF1);
        step();
        check_eq("t1_vld_low", res_vld_out, 0);
        check_eq("t1_res_hold", res_out, 36'hF_FFFF_FFF1);

        // All four ports together from pointer 0
        do_reset();
        for (int p = 0; p < PORTS_N; p++) set_ops(p, DATA_W'(p + 1), DATA_W'(-(p + 2)));
        req_in = '1;
        for (int i = 0; i < 10 && ack_log.size() < 4; i++) step();
        check_eq("t2_cnt", ack_log.size(), 4);
        for (int i = 0; i < ack_log.size(); i++) begin
            check_eq("t2_order", ack_log[i], i);
            check_eq("t2_b2b", ack_cyc[i] - ack_cyc[0], i);
        end
        drain("t2");
        set_ops(0, DATA_W'(11), DATA_W'(12));
        set_ops(3, DATA_W'(-13), DATA_W'(14));
        req_in = 4'b1001;
        step();
        check_eq("t2_ptr0", ack_out, 4'b0001);
        drain("t2b");

        // Port 0 and port 2 request continuously
        do_reset();
        hold = 4'b0101;
        set_ops(0, DATA_W'(100), DATA_W'(-200));
        set_ops(2, DATA_W'(-300), DATA_W'(400));
        req_in = 4'b0101;
        repeat (22) step();
        req_in = '0;
        hold   = '0;
        drain("t3");
        check_eq("t3_cnt", ack_log.size() >= 8, 1);
        for (int i = 0; i < ack_log.size(); i++) begin
            check_eq("t3_alt", ack_log[i], (i % 2 == 0) ? 0 : 2);
            if (i + 2 < ack_log.size())
                check_eq("t3_reissue", ack_cyc[i+2] - ack_cyc[i], MUL_LAT + 2);
        end

        // Largest-magnitude operands
        set_ops(2, 18'h20000, 18'h20000);
        req_in[2] = 1'b1;
        drain("t4");
        check_eq("t4_res", res_out, 36'h4_0000_0000);

        // Reset with three operations in flight
        do_reset();
        set_ops(0, DATA_W'(5), DATA_W'(6));
        set_ops(1, DATA_W'(-7), DATA_W'(8));
        set_ops(2, DATA_W'(9), DATA_W'(-10));
        req_in = 4'b0111;
        repeat (3) step();
        check_eq("t5_inflight", sb_q.size(), 3);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("t5_flush", res_vld_out, 0);
        end
        set_ops(3, DATA_W'(7), DATA_W'(-9));
        req_in[3] = 1'b1;
        drain("t5");
        check_eq("t5_res", res_out, 36'hF_FFFF_FFC1);

        // Arbitration policy distinguishes rr pointer from fixed priority
        do_reset();
        set_ops(2, DATA_W'(2), DATA_W'(2));
        req_in[2] = 1'b1;
        drain("t7a");
        set_ops(0, DATA_W'(1), DATA_W'(3));
        set_ops(3, DATA_W'(4), DATA_W'(5));
        req_in = 4'b1001;
        step();
`ifdef MUL_SHARE_FIXED_PRIO_EN
        check_eq("t7_policy", ack_out, 4'b0001);
`else
        check_eq("t7_policy", ack_out, 4'b1000);
`endif
        drain("t7b");

`ifdef MUL_SHARE_FIXED_PRIO_EN
        // Ports 1 and 3 continuously: port 1 wins whenever it is not pending
        do_reset();
        hold = 4'b1010;
        set_ops(1, DATA_W'(21), DATA_W'(22));
        set_ops(3, DATA_W'(23), DATA_W'(24));
        req_in = 4'b1010;
        for (int i = 0; i < 20; i++) begin
            logic [PORTS_N-1:0] snap;
            snap = outstanding;
            step();
            if (!snap[1]) check_eq("t6_p1_wins", ack_out, 4'b0010);
        end
        req_in = '0;
        hold   = '0;
        drain("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
